mod_ctrl: RTL and testbench
===========================

MOD_CTRL -- requirements
Module: mod_ctrl

Interface
REQ-001 Parameter MAX_ITER, default 1024: subtraction-iteration limit used only when MOD_TIMEOUT_EN is defined.
REQ-002 Parameter CNT_W, default 32: width of the iteration counter.
REQ-003 The block SHALL have one clock, CLK, and a synchronous, active-high reset, RST.
REQ-004 Ports SHALL be, in this order:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- start  in  1  request a new a mod b operation; sampled in IDLE only.
- b  in  32  divisor; sampled for zero on the accepting edge.
- less_than  in  1  datapath flag: temp < b.
- select  out  1  datapath mux: 0 = load a, 1 = load temp-b.
- write_enable  out  1  datapath temp write strobe.
- result_enable  out  1  datapath result capture strobe.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  failed operation (divide by zero or timeout), valid while done=1.
- iter_count  out  CNT_W  number of SUB cycles in the current or last operation.

Function
REQ-005 The block SHALL be a Moore FSM with states IDLE, LOAD, CHECK, SUB, RESULT and DONE; strobes SHALL decode combinationally from state only.
REQ-006 IDLE: all strobes 0, busy=0; on start=1 with b!=0, go to LOAD and clear iter_count; on start=1 with b==0, go to DONE with err latched 1.
REQ-007 LOAD: select=0, write_enable=1; next state CHECK.
REQ-008 CHECK: no strobes; less_than=1 -> RESULT; less_than=0 -> SUB.
REQ-009 SUB: select=1, write_enable=1, iter_count increments by 1; next state CHECK.
REQ-010 RESULT: result_enable=1, write_enable=0; next state DONE.
REQ-011 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 err SHALL clear when a new operation is accepted and hold its value until the next accepted start.
REQ-014 Latency: with q = a/b, done SHALL assert in the cycle 2q+4 cycles after the edge that samples start; for b==0 it SHALL assert in the next cycle.
REQ-015 start while busy=1 SHALL be ignored, with no queuing.
REQ-016 write_enable and result_enable SHALL never be 1 in the same cycle.
REQ-017 iter_count SHALL saturate at all ones and never wrap.

Reset
REQ-018 On RST=1 at a clock edge, the state SHALL go to IDLE and select, write_enable, result_enable, busy, done, err and iter_count SHALL all go to 0.
REQ-019 RST SHALL override start in the same cycle; reset mid-operation SHALL abort with no done pulse and no result_enable.

Configuration
REQ-020 Macro MOD_TIMEOUT_EN defined: in CHECK with less_than=0 and iter_count==MAX_ITER, the FSM SHALL go to DONE with err=1 and no result_enable.
REQ-021 Macro MOD_TIMEOUT_EN undefined: there SHALL be no iteration limit, and MAX_ITER SHALL be unused.

Verification
REQ-022 Bench paired with the mod datapath: a=17, b=5, start pulse -> 3 SUB cycles, done in cycle 10, err=0, iter_count=3, datapath result=2.
REQ-023 a=3, b=7 -> no SUB cycles, done in cycle 4, iter_count=0, result=3.
REQ-024 b=0, start -> done in cycle 1, err=1, no write_enable and no result_enable ever asserted.
REQ-025 MOD_TIMEOUT_EN defined, MAX_ITER=1024, a=5000, b=1 -> done with err=1, iter_count=1024, result_enable never asserted.
REQ-026 a=100, b=7; RST asserted in the 5th SUB cycle -> next cycle is IDLE with all outputs 0; a new start with a=9, b=4 -> done in cycle 8, result=1.
REQ-027 start held high through an operation -> exactly one done per IDLE acceptance, and a second operation starts only on the cycle after done.

Source files
------------

// File: rtl/mod_ctrl.sv
// -----------------------------------------------------------------------------
// mod_ctrl -- control FSM for an iterative "a mod b" datapath.
//
// The datapath holds a temp register and a result register. This controller
// loads temp with a, repeatedly subtracts b while temp >= b (signalled by the
// datapath's less_than flag), then strobes the remainder into the result
// register and pulses done. A zero divisor short-circuits straight to done
// with err set.
//
// Optional feature: define MOD_TIMEOUT_EN to abort with err=1 once MAX_ITER
// subtract cycles have run without reaching temp < b. With the macro
// undefined there is no iteration limit and MAX_ITER is not used.
// -----------------------------------------------------------------------------
module mod_ctrl #(
    parameter int unsigned MAX_ITER = 1024,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [31:0]      b,
    input  logic             less_than,
    output logic             select,
    output logic             write_enable,
    output logic             result_enable,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_SUB,
        S_RESULT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    logic             iter_at_limit;
    logic             iter_all_ones;

    assign iter_all_ones = &iter_q;

`ifdef MOD_TIMEOUT_EN
    // Compare in a wide domain so a limit larger than the counter can hold
    // never aliases onto a small count through truncation.
    localparam longint unsigned ITER_LIMIT = longint'(MAX_ITER);
    assign iter_at_limit = (64'(iter_q) == ITER_LIMIT);
`else
    assign iter_at_limit = 1'b0;
`endif

    // State, error flag and iteration counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (RST) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state logic plus Moore strobes decoded from the current state only.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        err_d         = err_q;
        iter_d        = iter_q;
        select        = 1'b0;
        write_enable  = 1'b0;
        result_enable = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    // Accepting a request clears the previous status.
                    iter_d = '0;
                    if (b == 32'd0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                select       = 1'b0;
                write_enable = 1'b1;
                state_d      = S_CHECK;
            end

            S_CHECK: begin
                if (less_than) begin
                    state_d = S_RESULT;
                end else if (iter_at_limit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SUB;
                end
            end

            S_SUB: begin
                select       = 1'b1;
                write_enable = 1'b1;
                // Saturate rather than wrap so a huge quotient is still
                // reported as "at least this many".
                if (!iter_all_ones) begin
                    iter_d = iter_q + CNT_W'(1);
                end
                state_d = S_CHECK;
            end

            S_RESULT: begin
                result_enable = 1'b1;
                state_d       = S_DONE;
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err        = err_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_mod_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod_ctrl -- directed self-checking bench for mod_ctrl.
//
// A behavioural mod datapath (temp/result registers, less_than compare) sits
// next to each DUT so real remainders come back. A second instance with a
// 3-bit counter exercises counter saturation. Inputs are driven and outputs
// sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mod_ctrl;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned CNT_W_S = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             start;
    logic [31:0]      b;
    logic             less_than;
    logic             select;
    logic             write_enable;
    logic             result_enable;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter_count;

    logic               start_s;
    logic [31:0]        b_s;
    logic               less_than_s;
    logic               select_s;
    logic               write_enable_s;
    logic               result_enable_s;
    logic               busy_s;
    logic               done_s;
    logic               err_s;
    logic [CNT_W_S-1:0] iter_count_s;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    always #5 CLK = ~CLK;

    mod_ctrl #(.MAX_ITER(1024), .CNT_W(CNT_W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .b             (b),
        .less_than     (less_than),
        .select        (select),
        .write_enable  (write_enable),
        .result_enable (result_enable),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .iter_count    (iter_count)
    );

    mod_ctrl #(.MAX_ITER(1024), .CNT_W(CNT_W_S)) dut_s (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start_s),
        .b             (b_s),
        .less_than     (less_than_s),
        .select        (select_s),
        .write_enable  (write_enable_s),
        .result_enable (result_enable_s),
        .busy          (busy_s),
        .done          (done_s),
        .err           (err_s),
        .iter_count    (iter_count_s)
    );

    // Behavioural datapaths paired with each controller.
    logic [31:0] a_v, temp_q = '0, result_q = '0;
    logic [31:0] a_s, temp_s = '0, result_s = '0;

    assign less_than   = (temp_q < b);
    assign less_than_s = (temp_s < b_s);

    always @(posedge CLK) begin
        if (write_enable)    temp_q   <= select ? (temp_q - b) : a_v;
        if (result_enable)   result_q <= temp_q;
        if (write_enable_s)  temp_s   <= select_s ? (temp_s - b_s) : a_s;
        if (result_enable_s) result_s <= temp_s;
    end

    // Free-running strobe counters; checks compare deltas against a baseline.
    int unsigned we_cnt = 0, re_cnt = 0, done_cnt = 0, overlap_cnt = 0;

    always @(posedge CLK) begin
        if (write_enable === 1'b1)  we_cnt   <= we_cnt + 1;
        if (result_enable === 1'b1) re_cnt   <= re_cnt + 1;
        if (done === 1'b1)          done_cnt <= done_cnt + 1;
        if (write_enable === 1'b1 && result_enable === 1'b1)
            overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Called in cycle 1 after the accepting edge; returns the cycle in which
    // done was seen (or the budget if it never came).
    task automatic wait_done(input int budget, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < budget) begin
            step();
            cyc++;
        end
    endtask

    task automatic pulse_start(input logic [31:0] av, input logic [31:0] bv);
        a_v   = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int          cyc;
    int unsigned we_base, re_base, done_base;

    initial begin
        RST     = 1'b1;
        start   = 1'b0;
        b       = 32'd0;
        a_v     = 32'd0;
        start_s = 1'b0;
        b_s     = 32'd1;
        a_s     = 32'd0;
        step();
        step();

        // Reset state
        check("rst_busy",   64'(busy),          64'd0);
        check("rst_strobe", 64'({select, write_enable, result_enable}), 64'd0);
        check("rst_done",   64'(done),          64'd0);
        check("rst_err",    64'(err),           64'd0);
        check("rst_iter",   64'(iter_count),    64'd0);
        RST = 1'b0;
        step();

        // 17 mod 5: q=3
        re_base = re_cnt;
        pulse_start(32'd17, 32'd5);
        check("op17_load", 64'({busy, select, write_enable}), 64'b101);
        wait_done(60, cyc);
        check("op17_lat",    64'(cyc),        64'd10);
        check("op17_done",   64'(done),       64'd1);
        check("op17_err",    64'(err),        64'd0);
        check("op17_iter",   64'(iter_count), 64'd3);
        check("op17_result", 64'(result_q),   64'd2);
        check("op17_re_cnt", 64'(re_cnt - re_base), 64'd1);
        step();
        check("op17_pulse", 64'({busy, done}), 64'b00);

        // 3 mod 7: q=0
        pulse_start(32'd3, 32'd7);
        wait_done(60, cyc);
        check("op3_lat",    64'(cyc),        64'd4);
        check("op3_iter",   64'(iter_count), 64'd0);
        check("op3_result", 64'(result_q),   64'd3);
        step();

        // Divide by zero
        we_base = we_cnt;
        re_base = re_cnt;
        pulse_start(32'd9, 32'd0);
        check("div0_done", 64'(done), 64'd1);
        check("div0_err",  64'(err),  64'd1);
        check("div0_busy", 64'(busy), 64'd1);
        step();
        check("div0_idle",  64'({busy, done}), 64'b00);
        check("div0_hold",  64'(err),  64'd1);
        step();
        step();
        check("div0_we_cnt", 64'(we_cnt - we_base), 64'd0);
        check("div0_re_cnt", 64'(re_cnt - re_base), 64'd0);

        // A new accepted start clears err immediately
        pulse_start(32'd3, 32'd7);
        check("errclr", 64'(err), 64'd0);
        wait_done(60, cyc);
        check("errclr_done", 64'({done, err}), 64'b10);
        step();

        // Reset in the 5th SUB cycle of 100 mod 7
        pulse_start(32'd100, 32'd7);
        for (int k = 1; k < 11; k++) step();
        check("abort_in_sub", 64'({select, write_enable, iter_count[3:0]}), 64'({2'b11, 4'd4}));
        re_base   = re_cnt;
        done_base = done_cnt;
        RST   = 1'b1;
        start = 1'b1;
        step();
        RST   = 1'b0;
        start = 1'b0;
        check("abort_outs", 64'({select, write_enable, result_enable, busy, done, err}), 64'd0);
        check("abort_iter", 64'(iter_count), 64'd0);
        step();
        check("abort_still_idle", 64'(busy), 64'd0);
        check("abort_no_re",   64'(re_cnt - re_base),     64'd0);
        check("abort_no_done", 64'(done_cnt - done_base), 64'd0);

        // 9 mod 4 after the abort: q=2
        pulse_start(32'd9, 32'd4);
        wait_done(60, cyc);
        check("op9_lat",    64'(cyc),      64'd8);
        check("op9_result", 64'(result_q), 64'd1);
        step();

        // start held high through a whole operation
        done_base = done_cnt;
        a_v   = 32'd17;
        b     = 32'd5;
        start = 1'b1;
        step();
        wait_done(60, cyc);
        check("hold_lat", 64'(cyc), 64'd10);
        step();
        check("hold_gap_idle", 64'(busy), 64'd0);
        check("hold_one_done", 64'(done_cnt - done_base), 64'd1);
        step();
        check("hold_restart", 64'({busy, select, write_enable}), 64'b101);
        start = 1'b0;
        wait_done(60, cyc);
        check("hold_lat2", 64'(cyc), 64'd10);
        step();
        check("hold_two_done", 64'(done_cnt - done_base), 64'd2);

`ifdef MOD_TIMEOUT_EN
        // Timeout at MAX_ITER=1024 with 5000 mod 1
        re_base = re_cnt;
        pulse_start(32'd5000, 32'd1);
        wait_done(3000, cyc);
        check("tmo_done",   64'(done),       64'd1);
        check("tmo_err",    64'(err),        64'd1);
        check("tmo_iter",   64'(iter_count), 64'd1024);
        check("tmo_no_re",  64'(re_cnt - re_base), 64'd0);
        step();
`else
        // No iteration limit: 2100 mod 1 runs past 1024 subtractions
        pulse_start(32'd2100, 32'd1);
        wait_done(5000, cyc);
        check("nolim_lat",    64'(cyc),        64'd4204);
        check("nolim_err",    64'(err),        64'd0);
        check("nolim_iter",   64'(iter_count), 64'd2100);
        check("nolim_result", 64'(result_q),   64'd0);
        step();
`endif

        // Counter saturation on the 3-bit instance: 10 mod 1
        a_s     = 32'd10;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        cyc = 1;
        while (done_s !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        check("sat_lat",    64'(cyc),          64'd24);
        check("sat_iter",   64'(iter_count_s), 64'd7);
        check("sat_result", 64'(result_s),     64'd0);
        check("sat_err",    64'(err_s),        64'd0);
        step();

        check("we_re_exclusive", 64'(overlap_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
